// File: rtl/bg_pkg.sv
// ---------------------------------------------------------------------------
// bg_pkg
// Shared definitions for the bandgap trim sequencer: FSM state encoding, trim
// code widths, reset trim codes (shared with the bandgap digital block) and
// the absolute-delta helper used by the lock detector.
// ---------------------------------------------------------------------------
package bg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PWRUP   = 3'd1,
        ST_CONVERT = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_ERROR   = 3'd4
    } bg_state_t;

    localparam int TRIM_W  = 8;
    localparam int DELTA_W = TRIM_W + 1;   // signed difference of two trim codes
    localparam int CAL_W   = 8;

    // Mid-scale codes the bandgap block powers up with.
    localparam logic [TRIM_W-1:0] TRIM_FINE_RST   = 8'h7F;
    localparam logic [TRIM_W-1:0] TRIM_COARSE_RST = 8'h80;
    localparam logic [CAL_W-1:0]  CAL_MAX         = 8'hFF;

    // |a - b| computed in 9-bit signed arithmetic so 8'h00 vs 8'hFF gives 255
    // rather than wrapping.
    function automatic logic [DELTA_W-1:0] abs_delta(input logic [TRIM_W-1:0] a,
                                                     input logic [TRIM_W-1:0] b);
        logic signed [DELTA_W-1:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        return (diff < 0) ? $unsigned(-diff) : $unsigned(diff);
    endfunction

endpackage

// File: rtl/bg_lock_detect.sv
// ---------------------------------------------------------------------------
// bg_lock_detect
// Qualifies bandgap results and counts consecutive tolerance outcomes.
//  - One sample per bg_valid rising edge, ignored while bg_coarse=1.
//  - CONVERT mode (track=0): each sample is compared with the previous one;
//    the first sample after enable only primes the reference. run_done fires
//    on the in-tolerance sample that completes LOCK_SAMPLES stable samples.
//  - LOCKED mode (track=1): samples are compared with the latched trim codes;
//    run_done fires on the LOCK_SAMPLES-th consecutive out-of-tolerance one.
// Ports
//  clk, reset        clock, asynchronous active-high reset
//  enable            sampling allowed (CONVERT/LOCKED and no stop this cycle)
//  track             1 = compare against ref_fine/ref_crs (LOCKED)
//  bg_valid          result strobe from bandgap block
//  bg_coarse         bandgap block still in coarse SAR phase
//  fine, crs         current fine / coarse codes
//  ref_fine, ref_crs latched trim codes used in track mode
//  sample_strobe     qualified sample this cycle
//  in_tol            current sample within tolerance of its reference
//  run_done          lock (track=0) or unlock (track=1) condition met
// ---------------------------------------------------------------------------
module bg_lock_detect
    import bg_pkg::*;
#(
    parameter int LOCK_SAMPLES = 4,
    parameter int LOCK_TOL     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              track,
    input  logic              bg_valid,
    input  logic              bg_coarse,
    input  logic [TRIM_W-1:0] fine,
    input  logic [TRIM_W-1:0] crs,
    input  logic [TRIM_W-1:0] ref_fine,
    input  logic [TRIM_W-1:0] ref_crs,
    output logic              sample_strobe,
    output logic              in_tol,
    output logic              run_done
);

    localparam int CNT_W = $clog2(LOCK_SAMPLES + 1);
    // Stable run: the primer plus LOCK_SAMPLES-1 in-tolerance deltas.
    localparam logic [CNT_W-1:0]   LOCK_LAST  = CNT_W'(LOCK_SAMPLES - 1);
    localparam logic [CNT_W-1:0]   DRIFT_LAST = CNT_W'(LOCK_SAMPLES);
    localparam logic [DELTA_W-1:0] TOL        = DELTA_W'(LOCK_TOL);

    logic              valid_d;
    logic              primed;
    logic [TRIM_W-1:0] prev_fine;
    logic [TRIM_W-1:0] prev_crs;
    logic [CNT_W-1:0]  run_cnt;
    logic [CNT_W-1:0]  run_next;
    logic [TRIM_W-1:0] cmp_fine;
    logic [TRIM_W-1:0] cmp_crs;

    // NOTE: every output of this block is assigned a default at the top so
    // no path leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        cmp_fine      = track ? ref_fine : prev_fine;
        cmp_crs       = track ? ref_crs  : prev_crs;
        sample_strobe = enable && bg_valid && !valid_d && !bg_coarse;
        in_tol        = (track || primed) &&
                        (abs_delta(fine, cmp_fine) <= TOL) && (crs == cmp_crs);
        run_next      = run_cnt + 1'b1;
        run_done      = 1'b0;
        if (sample_strobe) begin
            if (track) begin
                run_done = !in_tol && (run_next == DRIFT_LAST);
            end else begin
                run_done = in_tol && (run_next == LOCK_LAST);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_d   <= 1'b0;
            primed    <= 1'b0;
            // NOTE: the reference codes are plain datapath registers but are
            // still reset, so in_tol never sees X before the first sample.
            prev_fine <= '0;
            prev_crs  <= '0;
            run_cnt   <= '0;
        end else begin
            valid_d <= bg_valid;
            if (!enable) begin
                // Leaving CONVERT/LOCKED: the next calibration re-primes.
                primed  <= 1'b0;
                run_cnt <= '0;
            end else if (sample_strobe) begin
                prev_fine <= fine;
                prev_crs  <= crs;
                primed    <= 1'b1;
                if (run_done) begin
                    // Mode flips on this edge; the new mode starts counting at 0.
                    run_cnt <= '0;
                end else if (track) begin
                    run_cnt <= in_tol ? '0 : run_next;
                end else begin
                    run_cnt <= in_tol ? run_next : '0;
                end
            end
        end
    end

endmodule

// File: rtl/bg_cal_sequencer.sv
// ---------------------------------------------------------------------------
// bg_cal_sequencer
// Sequences the bandgap SAR trim controller: power-up, reset hold through
// analog settling, lock detection on the trim results, drift tracking while
// locked and optional periodic recalibration.
// Ports
//  clk, reset     10 MHz clock, asynchronous active-high reset
//  start          one-cycle request to begin calibration (ignored while busy)
//  stop           one-cycle request to abort and power down (wins over start)
//  bg_valid       result strobe from bandgap block (high 2 cycles per result)
//  bg_coarse      bandgap block still in coarse SAR phase
//  bg_idac_fine   fine IDAC code from bandgap block
//  bg_idac_crs    coarse IDAC code from bandgap block
//  bg_reset       reset to bandgap block
//  bg_pwrup       power-up to bandgap block
//  trim_fine      latched fine trim code
//  trim_coarse    latched coarse trim code
//  locked         trim codes stable and valid
//  busy           state is PWRUP, CONVERT or LOCKED
//  timeout_err    sticky: calibration failed to lock, cleared by start
//  cal_count      completed lock events, saturating
// ---------------------------------------------------------------------------
module bg_cal_sequencer
    import bg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int LOCK_SAMPLES   = 4,
    parameter int LOCK_TOL       = 2,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int RECAL_PERIOD   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              bg_valid,
    input  logic              bg_coarse,
    input  logic [TRIM_W-1:0] bg_idac_fine,
    input  logic [TRIM_W-1:0] bg_idac_crs,
    output logic              bg_reset,
    output logic              bg_pwrup,
    output logic [TRIM_W-1:0] trim_fine,
    output logic [TRIM_W-1:0] trim_coarse,
    output logic              locked,
    output logic              busy,
    output logic              timeout_err,
    output logic [CAL_W-1:0]  cal_count
);

    localparam int SETTLE_W  = (SETTLE_CYCLES  > 1) ? $clog2(SETTLE_CYCLES)  : 1;
    localparam int TIMEOUT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RECAL_W   = (RECAL_PERIOD   > 1) ? $clog2(RECAL_PERIOD)   : 1;

    // Each counter starts at 0 on state entry, so the exit compare is N-1.
    localparam logic [SETTLE_W-1:0]  SETTLE_LAST  = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RECAL_W-1:0]   RECAL_LAST   = RECAL_W'(RECAL_PERIOD - 1);

    bg_state_t            state;
    logic [SETTLE_W-1:0]  settle_cnt;
    logic [TIMEOUT_W-1:0] timeout_cnt;
    logic [RECAL_W-1:0]   recal_cnt;

    logic det_enable;
    logic det_track;
    logic sample_strobe;
    logic in_tol;
    logic run_done;

    // A stop cycle discards any bg_valid edge arriving with it.
    assign det_enable = ((state == ST_CONVERT) || (state == ST_LOCKED)) && !stop;
    assign det_track  = (state == ST_LOCKED);

    bg_lock_detect #(
        .LOCK_SAMPLES (LOCK_SAMPLES),
        .LOCK_TOL     (LOCK_TOL)
    ) u_lock_detect (
        .clk           (clk),
        .reset         (reset),
        .enable        (det_enable),
        .track         (det_track),
        .bg_valid      (bg_valid),
        .bg_coarse     (bg_coarse),
        .fine          (bg_idac_fine),
        .crs           (bg_idac_crs),
        .ref_fine      (trim_fine),
        .ref_crs       (trim_coarse),
        .sample_strobe (sample_strobe),
        .in_tol        (in_tol),
        .run_done      (run_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            bg_reset    <= 1'b1;
            bg_pwrup    <= 1'b0;
            trim_fine   <= TRIM_FINE_RST;
            trim_coarse <= TRIM_COARSE_RST;
            locked      <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            cal_count   <= '0;
            settle_cnt  <= '0;
            timeout_cnt <= '0;
            recal_cnt   <= '0;
        end else if (stop) begin
            // Abort from any state; trim codes and timeout_err are kept.
            state       <= ST_IDLE;
            bg_reset    <= 1'b1;
            bg_pwrup    <= 1'b0;
            locked      <= 1'b0;
            busy        <= 1'b0;
            settle_cnt  <= '0;
            timeout_cnt <= '0;
            recal_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_ERROR: begin
                    if (start) begin
                        state       <= ST_PWRUP;
                        bg_pwrup    <= 1'b1;
                        bg_reset    <= 1'b1;
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                        settle_cnt  <= '0;
                    end
                end

                ST_PWRUP: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state       <= ST_CONVERT;
                        bg_reset    <= 1'b0;
                        settle_cnt  <= '0;
                        timeout_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end

                ST_CONVERT: begin
                    // A lock on the final timeout cycle still counts as a lock.
                    if (run_done) begin
                        state       <= ST_LOCKED;
                        locked      <= 1'b1;
                        trim_fine   <= bg_idac_fine;
                        trim_coarse <= bg_idac_crs;
                        if (cal_count != CAL_MAX) begin
                            cal_count <= cal_count + 1'b1;
                        end
                        timeout_cnt <= '0;
                        recal_cnt   <= '0;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        state       <= ST_ERROR;
                        bg_pwrup    <= 1'b0;
                        bg_reset    <= 1'b1;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        timeout_cnt <= '0;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end

                ST_LOCKED: begin
                    if ((RECAL_PERIOD != 0) && (recal_cnt == RECAL_LAST)) begin
                        // Forced recalibration: full power-up sequence again.
                        state      <= ST_PWRUP;
                        locked     <= 1'b0;
                        bg_reset   <= 1'b1;
                        settle_cnt <= '0;
                        recal_cnt  <= '0;
                    end else if (run_done) begin
                        // Drifted: reconverge without resetting the bandgap.
                        state       <= ST_CONVERT;
                        locked      <= 1'b0;
                        timeout_cnt <= '0;
                        recal_cnt   <= '0;
                    end else if (RECAL_PERIOD != 0) begin
                        recal_cnt <= recal_cnt + 1'b1;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    bg_reset <= 1'b1;
                    bg_pwrup <= 1'b0;
                    locked   <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bg_cal_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bg_cal_sequencer
// Self-checking bench for bg_cal_sequencer with shortened timing parameters.
// ---------------------------------------------------------------------------
module tb_bg_cal_sequencer;

    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 300;
    localparam int RECAL   = 500;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       bg_valid;
    logic       bg_coarse;
    logic [7:0] bg_idac_fine;
    logic [7:0] bg_idac_crs;
    logic       bg_reset;
    logic       bg_pwrup;
    logic [7:0] trim_fine;
    logic [7:0] trim_coarse;
    logic       locked;
    logic       busy;
    logic       timeout_err;
    logic [7:0] cal_count;

    bg_cal_sequencer #(
        .SETTLE_CYCLES  (SETTLE),
        .LOCK_SAMPLES   (4),
        .LOCK_TOL       (2),
        .TIMEOUT_CYCLES (TIMEOUT),
        .RECAL_PERIOD   (RECAL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .bg_valid     (bg_valid),
        .bg_coarse    (bg_coarse),
        .bg_idac_fine (bg_idac_fine),
        .bg_idac_crs  (bg_idac_crs),
        .bg_reset     (bg_reset),
        .bg_pwrup     (bg_pwrup),
        .trim_fine    (trim_fine),
        .trim_coarse  (trim_coarse),
        .locked       (locked),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .cal_count    (cal_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Cycle stamps of output edges, used to measure interval lengths.
    int   cyc = 0;
    int   t_pwrup_rise = 0, t_reset_rise = 0, t_reset_fall = 0;
    int   t_lock_rise = 0, t_err_rise = 0;
    logic p_rst = 1'b1, p_pwr = 1'b0, p_lock = 1'b0, p_terr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!p_pwr && bg_pwrup)     t_pwrup_rise <= cyc;
        if (!p_rst && bg_reset)     t_reset_rise <= cyc;
        if (p_rst && !bg_reset)     t_reset_fall <= cyc;
        if (!p_lock && locked)      t_lock_rise  <= cyc;
        if (!p_terr && timeout_err) t_err_rise   <= cyc;
        p_rst  <= bg_reset;
        p_pwr  <= bg_pwrup;
        p_lock <= locked;
        p_terr <= timeout_err;
    end

    typedef struct {
        logic [7:0] fine;
        logic [7:0] crs;
        logic       coarse_phase;
        logic       exp_locked;
        logic [7:0] exp_trim_fine;
        logic [7:0] exp_trim_crs;
        logic [7:0] exp_cal;
        logic       exp_bg_reset;
    } vec_t;

    localparam int N_VEC = 11;
    vec_t vecs [N_VEC];
    vec_t sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    // One bandgap result: bg_valid high for two cycles, then two low.
    task automatic bg_result(input logic [7:0] f, input logic [7:0] c, input logic cph);
        @(negedge clk);
        bg_idac_fine = f;
        bg_idac_crs  = c;
        bg_coarse    = cph;
        bg_valid     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bg_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_bg_reset(input logic level, input int max_cyc, input string name);
        int n;
        n = 0;
        while (bg_reset !== level && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(name, bg_reset, level);
    endtask

    task automatic check_outputs_idle(input string tag, input logic [7:0] tf, input logic [7:0] tc,
                                      input logic [7:0] cal);
        check({tag, "_bg_reset"},  bg_reset,    1'b1);
        check({tag, "_bg_pwrup"},  bg_pwrup,    1'b0);
        check({tag, "_locked"},    locked,      1'b0);
        check({tag, "_busy"},      busy,        1'b0);
        check({tag, "_trim_fine"}, trim_fine,   tf);
        check({tag, "_trim_crs"},  trim_coarse, tc);
        check({tag, "_cal_count"}, cal_count,   cal);
    endtask

    task automatic sb_compare(input int idx);
        vec_t e;
        string tag;
        tag = $sformatf("vec%0d", idx);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_locked"},    locked,      e.exp_locked);
            check({tag, "_trim_fine"}, trim_fine,   e.exp_trim_fine);
            check({tag, "_trim_crs"},  trim_coarse, e.exp_trim_crs);
            check({tag, "_cal_count"}, cal_count,   e.exp_cal);
            check({tag, "_bg_reset"},  bg_reset,    e.exp_bg_reset);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // fine, crs, coarse phase | locked, trim_fine, trim_crs, cal, bg_reset
        vecs[0]  = '{8'h7A, 8'h40, 1'b0, 1'b0, 8'h7F, 8'h80, 8'd0, 1'b0}; // primes
        vecs[1]  = '{8'h7B, 8'h40, 1'b0, 1'b0, 8'h7F, 8'h80, 8'd0, 1'b0};
        vecs[2]  = '{8'h10, 8'h40, 1'b1, 1'b0, 8'h7F, 8'h80, 8'd0, 1'b0}; // coarse phase: ignored
        vecs[3]  = '{8'h7A, 8'h40, 1'b0, 1'b0, 8'h7F, 8'h80, 8'd0, 1'b0};
        vecs[4]  = '{8'h7B, 8'h40, 1'b0, 1'b1, 8'h7B, 8'h40, 8'd1, 1'b0}; // 4th stable: lock
        vecs[5]  = '{8'h80, 8'h40, 1'b0, 1'b1, 8'h7B, 8'h40, 8'd1, 1'b0}; // drift 1
        vecs[6]  = '{8'h7D, 8'h40, 1'b0, 1'b1, 8'h7B, 8'h40, 8'd1, 1'b0}; // delta 2: clears drift
        vecs[7]  = '{8'h7E, 8'h40, 1'b0, 1'b1, 8'h7B, 8'h40, 8'd1, 1'b0}; // delta 3: drift 1
        vecs[8]  = '{8'h7B, 8'h41, 1'b0, 1'b1, 8'h7B, 8'h40, 8'd1, 1'b0}; // coarse differs: drift 2
        vecs[9]  = '{8'h78, 8'h40, 1'b0, 1'b1, 8'h7B, 8'h40, 8'd1, 1'b0}; // delta -3: drift 3
        vecs[10] = '{8'h80, 8'h40, 1'b0, 1'b0, 8'h7B, 8'h40, 8'd1, 1'b0}; // drift 4: unlock

        start = 1'b0; stop = 1'b0; bg_valid = 1'b0; bg_coarse = 1'b0;
        bg_idac_fine = 8'h00; bg_idac_crs = 8'h00;

        // Reset state
        do_reset();
        check_outputs_idle("rst", 8'h7F, 8'h80, 8'd0);
        check("rst_timeout_err", timeout_err, 1'b0);

        // start and stop together in IDLE: stop wins
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        @(negedge clk);
        check("startstop_busy",  busy,     1'b0);
        check("startstop_pwrup", bg_pwrup, 1'b0);

        // Calibration to lock, then drift tracking to unlock
        pulse_start();
        check("pwrup_pwrup",    bg_pwrup, 1'b1);
        check("pwrup_bg_reset", bg_reset, 1'b1);
        check("pwrup_busy",     busy,     1'b1);
        wait_bg_reset(1'b0, 100, "settle_done");
        #1;
        check("settle_len", t_reset_fall - t_pwrup_rise, SETTLE);
        for (int i = 0; i < N_VEC; i++) begin
            sb_q.push_back(vecs[i]);
            bg_result(vecs[i].fine, vecs[i].crs, vecs[i].coarse_phase);
            sb_compare(i);
        end
        check("unlock_busy",  busy,     1'b1);
        check("unlock_pwrup", bg_pwrup, 1'b1);

        // stop keeps trim codes
        pulse_stop();
        check_outputs_idle("stop", 8'h7B, 8'h40, 8'd1);

        // Alternating 70/78 never locks: timeout
        pulse_start();
        wait_bg_reset(1'b0, 100, "to_settle_done");
        for (int i = 0; i < 150 && timeout_err !== 1'b1; i++) begin
            bg_result((i % 2 == 1) ? 8'h78 : 8'h70, 8'h40, 1'b0);
        end
        check("to_flag",     timeout_err, 1'b1);
        check("to_pwrup",    bg_pwrup,    1'b0);
        check("to_bg_reset", bg_reset,    1'b1);
        check("to_busy",     busy,        1'b0);
        check("to_locked",   locked,      1'b0);
        #1;
        check("to_len", t_err_rise - t_reset_fall, TIMEOUT);
        pulse_start();
        check("to_clear_flag",  timeout_err, 1'b0);
        check("to_clear_pwrup", bg_pwrup,    1'b1);
        check("to_clear_busy",  busy,        1'b1);

        // Fresh run: lock timing, periodic recalibration, relock
        do_reset();
        pulse_start();
        wait_bg_reset(1'b0, 100, "rc_settle_done");
        bg_result(8'h7A, 8'h40, 1'b0);
        bg_result(8'h7B, 8'h40, 1'b0);
        bg_result(8'h7A, 8'h40, 1'b0);
        @(negedge clk);
        bg_idac_fine = 8'h7B; bg_idac_crs = 8'h40; bg_coarse = 1'b0; bg_valid = 1'b1;
        check("lock_before_edge", locked, 1'b0);
        @(negedge clk);
        check("lock_after_edge",  locked,    1'b1);
        check("lock_trim_fine",   trim_fine, 8'h7B);
        check("lock_cal_count",   cal_count, 8'd1);
        @(negedge clk); bg_valid = 1'b0;
        @(negedge clk);
        wait_bg_reset(1'b1, RECAL + 50, "recal_fired");
        #1;
        check("recal_len", t_reset_rise - t_lock_rise, RECAL);
        check("recal_locked",    locked,    1'b0);
        check("recal_busy",      busy,      1'b1);
        check("recal_pwrup",     bg_pwrup,  1'b1);
        check("recal_trim_hold", trim_fine, 8'h7B);
        wait_bg_reset(1'b0, 100, "recal_settle_done");
        #1;
        check("recal_settle_len", t_reset_fall - t_reset_rise, SETTLE);
        bg_result(8'h7A, 8'h40, 1'b0);
        bg_result(8'h7B, 8'h40, 1'b0);
        bg_result(8'h7A, 8'h40, 1'b0);
        bg_result(8'h7B, 8'h40, 1'b0);
        check("relock_locked", locked,    1'b1);
        check("relock_cal",    cal_count, 8'd2);
        pulse_stop();
        check("stop_locked_clear", locked, 1'b0);

        // Asynchronous reset in the middle of CONVERT
        pulse_start();
        wait_bg_reset(1'b0, 100, "ar_settle_done");
        bg_result(8'h7A, 8'h40, 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_outputs_idle("areset", 8'h7F, 8'h80, 8'd0);
        check("areset_timeout_err", timeout_err, 1'b0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        check("areset_after_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
